// File: rtl/ls_seq.sv
// Sequential left shifter: loads an operand, shifts left one bit per clock, and tracks signed overflow in arith mode.
// Latency: done pulses in the cycle after edge amt (after edge 0 when amt=0); all outputs are registered.
// Backpressure: start is ignored while busy; a new start is accepted in the IDLE or DONE cycle.
module ls_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic             mode, mode_n;
    logic             ovf_acc, ovf_acc_n;
    logic [WIDTH-1:0] result_n;
    logic             ovf_n;
    logic [WIDTH-1:0] shifted;
    logic             step_ovf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            mode    <= 1'b0;
            ovf_acc <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            cnt     <= cnt_n;
            mode    <= mode_n;
            ovf_acc <= ovf_acc_n;
            result  <= result_n;
            ovf     <= ovf_n;
        end
    end

    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        cnt_n     = cnt;
        mode_n    = mode;
        ovf_acc_n = ovf_acc;
        result_n  = result;
        ovf_n     = ovf;
        shifted   = {sreg[WIDTH-2:0], 1'b0};
        // A left shift overflows whenever the two top bits differ before the move.
        step_ovf  = mode & (sreg[WIDTH-1] ^ sreg[WIDTH-2]);

        case (state)
            SHIFT: begin
                sreg_n    = shifted;
                cnt_n     = cnt - 1'b1;
                ovf_acc_n = ovf_acc | step_ovf;
                if (cnt <= AMT_W'(1)) begin
                    state_n  = DONE;
                    result_n = shifted;
                    ovf_n    = ovf_acc | step_ovf;
                end
            end
            default: begin
                if (start) begin
                    sreg_n    = din;
                    cnt_n     = amt;
                    mode_n    = arith;
                    ovf_acc_n = 1'b0;
                    if (amt == '0) begin
                        state_n  = DONE;
                        result_n = din;
                        ovf_n    = 1'b0;
                    end else begin
                        state_n = SHIFT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ls_seq.sv
// Directed and randomized checks of ls_seq against an arithmetic reference model.
module tb_ls_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] din;
    logic [4:0]  amt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_res = '0;
    logic        exp_ovf = 1'b0;

    ls_seq #(.WIDTH(32), .AMT_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .din     (din),
        .amt     (amt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf)
    );

    always #5 clock = ~clock;

    // Result is din * 2^a truncated; signed overflow means the exact product
    // does not fit, i.e. bits 63..31 of the sign-extended product disagree.
    function automatic logic [32:0] model(input logic [31:0] d, input int a, input logic ar);
        logic [63:0] sx;
        logic [63:0] sh;
        logic        o;
        sx = {{32{d[31]}}, d};
        sh = sx << a;
        o  = ar && !((&sh[63:31]) || !(|sh[63:31]));
        return {o, sh[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enters and leaves on a falling edge; leaves in the done cycle so the
    // caller may issue a back-to-back start. poke >= 0 pulses a stray start
    // during that cycle index of the operation.
    task automatic run_op(input logic [31:0] d, input int a, input logic ar, input int poke);
        logic [32:0] m;
        int          lat;
        int          bcnt;
        logic        held;
        m     = model(d, a, ar);
        din   = d;
        amt   = a[4:0];
        arith = ar;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        held  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            bcnt += int'(busy);
            if (result !== exp_res || ovf !== exp_ovf) held = 1'b0;
            if (k == poke) begin
                start = 1'b1;
                din   = 32'h1234_5678;
                amt   = 5'd3;
                arith = ~ar;
            end else if (k == poke + 1) begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        exp_res = m[31:0];
        exp_ovf = m[32];
        chk("latency", 64'(lat), 64'(a));
        chk("busy_cycles", 64'(bcnt), 64'(a));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("prev_result_held", 64'(held), 64'(1));
        chk("result", 64'(result), 64'(exp_res));
        chk("ovf", 64'(ovf), 64'(exp_ovf));
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        chk("done_one_pulse", 64'(done), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("result_hold", 64'(result), 64'(exp_res));
    endtask

    initial begin
        logic [31:0] d;
        int          a;
        logic        ar;

        reset_n = 1'b0;
        start   = 1'b0;
        din     = '0;
        amt     = '0;
        arith   = 1'b0;
        #12;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
        chk("reset_ovf", 64'(ovf), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        run_op(32'h0000_0001, 4, 1'b0, -1);
        chk("logical_4", 64'(result), 64'h10);
        idle_cycle();
        run_op(32'hDEAD_BEEF, 0, 1'b0, -1);
        chk("amt0", 64'(result), 64'hDEAD_BEEF);
        idle_cycle();
        run_op(32'hFFFF_FFFF, 31, 1'b1, -1);
        chk("amt31_res", 64'(result), 64'h8000_0000);
        chk("amt31_ovf", 64'(ovf), 64'(0));
        idle_cycle();
        run_op(32'h4000_0000, 1, 1'b1, -1);
        chk("ovf_set", 64'(ovf), 64'(1));
        idle_cycle();
        run_op(32'hC000_0000, 1, 1'b1, -1);
        chk("ovf_clear", 64'(ovf), 64'(0));
        idle_cycle();
        run_op(32'h4000_0000, 1, 1'b0, -1);
        chk("ovf_logical", 64'(ovf), 64'(0));
        idle_cycle();
        run_op(32'h0000_00FF, 8, 1'b0, 2);
        chk("start_ignored", 64'(result), 64'h0000_FF00);
        run_op(32'h0000_0001, 2, 1'b0, -1);
        chk("back_to_back", 64'(result), 64'h4);
        idle_cycle();

        // Reset in the middle of an amt=10 shift, just after edge 3.
        din   = 32'h0000_0005;
        amt   = 5'd10;
        arith = 1'b1;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_result", 64'(result), 64'(0));
        chk("midrst_ovf", 64'(ovf), 64'(0));
        exp_res = '0;
        exp_ovf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_op(32'h0000_0003, 1, 1'b0, -1);
        chk("after_reset", 64'(result), 64'h6);
        idle_cycle();

        for (int i = 0; i < 40; i++) begin
            d  = $urandom;
            if ($urandom_range(0, 1) == 1) d = 32'($signed(d) >>> $urandom_range(0, 31));
            a  = $urandom_range(0, 31);
            ar = 1'($urandom_range(0, 1));
            run_op(d, a, ar, -1);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
